// File: rtl/fridge_ctrl_multi_if.sv
// Bus bundle between the selector front end / sensors and the multi-compartment
// fridge controller. The master drives the inputs and the slave is the controller.
interface fridge_ctrl_multi_if #(
    parameter int unsigned N_COMP = 4,
    parameter int unsigned W      = 5,
    parameter int unsigned SEL_W  = 2
);
    // Front-end controls and sensors
    logic                pwr;
    logic [SEL_W-1:0]    sel;
    logic [1:0]          fld;
    logic                wr_en;
    logic [W-1:0]        wr_data;
    logic [N_COMP*W-1:0] temp_in;
    logic [N_COMP-1:0]   door;

    // Controller status and drive outputs
    logic [N_COMP*W-1:0] setpt;
    logic [N_COMP*W-1:0] cap;
    logic [N_COMP-1:0]   cool_on;
    logic [N_COMP-1:0]   comp_pwr;
    logic [N_COMP-1:0]   alarm;
    logic                wr_ack;

    modport master (
        output pwr, sel, fld, wr_en, wr_data, temp_in, door,
        input  setpt, cap, cool_on, comp_pwr, alarm, wr_ack
    );

    modport slave (
        input  pwr, sel, fld, wr_en, wr_data, temp_in, door,
        output setpt, cap, cool_on, comp_pwr, alarm, wr_ack
    );
endinterface

// File: rtl/fridge_ctrl_multi.sv
// Multi-compartment fridge controller. Each compartment has a register file
// (setpoint, capacity, enable), a hysteretic compressor FSM with a minimum-off
// lockout, and a door-open alarm timer. All outputs are registered.
module fridge_ctrl_multi #(
    parameter int unsigned N_COMP     = 4,
    parameter int unsigned W          = 5,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned HYST       = 2,
    parameter int unsigned MIN_OFF    = 8,
    parameter int unsigned DOOR_LIMIT = 16,
    parameter int unsigned DEF_SETPT  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fridge_ctrl_multi_if.slave bus
);

    localparam int unsigned NSEL    = 1 << SEL_W;
    localparam int unsigned TW      = W + 1;
    localparam int unsigned LK_W    = (MIN_OFF > 1) ? $clog2(MIN_OFF) : 1;
    localparam int unsigned LK_INIT = (MIN_OFF > 0) ? (MIN_OFF - 1) : 0;
    localparam int unsigned DC_W    = (DOOR_LIMIT > 0) ? $clog2(DOOR_LIMIT + 1) : 1;

    localparam logic [1:0] FLD_SETPT = 2'b00;
    localparam logic [1:0] FLD_CAP   = 2'b01;
    localparam logic [1:0] FLD_EN    = 2'b10;
    localparam logic [1:0] FLD_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_IDLE = 2'd1,
        S_COOL = 2'd2,
        S_LOCK = 2'd3
    } state_e;

    // Register file
    logic [W-1:0]      setpt_q [N_COMP];
    logic [W-1:0]      cap_q   [N_COMP];
    logic [N_COMP-1:0] en_q;
    logic              wr_ack_q;

    // Per-compartment control state
    state_e            st_q    [N_COMP];
    logic [LK_W-1:0]   lk_q    [N_COMP];
    logic [DC_W-1:0]   dc_q    [N_COMP];
    logic [N_COMP-1:0] cool_q;
    logic [N_COMP-1:0] cpwr_q;
    logic [N_COMP-1:0] alarm_q;

    // Combinational decode
    logic [NSEL-1:0]   sel_valid_c;
    logic              wr_ok_c;
    logic [W-1:0]      temp_c  [N_COMP];
    logic [N_COMP-1:0] powered_c;
    logic [N_COMP-1:0] hot_c;
    logic [N_COMP-1:0] cold_c;

    // Selector codes that map onto an existing compartment
    for (genvar i = 0; i < NSEL; i++) begin : g_sel
        assign sel_valid_c[i] = (i < N_COMP);
    end

    // A write needs power, an existing compartment and a defined field
    assign wr_ok_c = bus.wr_en & bus.pwr & sel_valid_c[bus.sel] & (bus.fld != FLD_RSVD);

    // Per-compartment power and hysteresis comparisons; the upper threshold is
    // one bit wider than the temperature so a high setpoint never wraps
    always_comb begin
        for (int unsigned k = 0; k < N_COMP; k++) begin
            temp_c[k]    = bus.temp_in[k*W +: W];
            powered_c[k] = bus.pwr & en_q[k];
            hot_c[k]     = {1'b0, temp_c[k]} > ({1'b0, setpt_q[k]} + TW'(HYST));
            cold_c[k]    = temp_c[k] <= setpt_q[k];
        end
    end

    // Register file writes and the one-cycle write acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_COMP; k++) begin
                setpt_q[k] <= W'(DEF_SETPT);
                cap_q[k]   <= '0;
            end
            en_q     <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            wr_ack_q <= wr_ok_c;
            for (int unsigned k = 0; k < N_COMP; k++) begin
                if (wr_ok_c && (bus.sel == SEL_W'(k))) begin
                    case (bus.fld)
                        FLD_SETPT: setpt_q[k] <= bus.wr_data;
                        FLD_CAP:   cap_q[k]   <= bus.wr_data;
                        FLD_EN:    en_q[k]    <= bus.wr_data[0];
                        default:   ;
                    endcase
                end
            end
        end
    end

    // Compressor FSMs with registered drive; loss of power or enable wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_COMP; k++) begin
                st_q[k] <= S_OFF;
                lk_q[k] <= '0;
            end
            cool_q <= '0;
        end else begin
            for (int unsigned k = 0; k < N_COMP; k++) begin
                if (!powered_c[k]) begin
                    st_q[k]   <= S_OFF;
                    lk_q[k]   <= '0;
                    cool_q[k] <= 1'b0;
                end else begin
                    case (st_q[k])
                        S_OFF: begin
                            st_q[k]   <= S_IDLE;
                            cool_q[k] <= 1'b0;
                        end
                        S_IDLE: begin
                            if (hot_c[k]) begin
                                st_q[k]   <= S_COOL;
                                cool_q[k] <= 1'b1;
                            end else begin
                                cool_q[k] <= 1'b0;
                            end
                        end
                        S_COOL: begin
                            if (cold_c[k]) begin
                                cool_q[k] <= 1'b0;
                                if (MIN_OFF == 0) begin
                                    st_q[k] <= S_IDLE;
                                end else begin
                                    st_q[k] <= S_LOCK;
                                    lk_q[k] <= LK_W'(LK_INIT);
                                end
                            end else begin
                                cool_q[k] <= 1'b1;
                            end
                        end
                        S_LOCK: begin
                            cool_q[k] <= 1'b0;
                            if (lk_q[k] == '0) begin
                                st_q[k] <= S_IDLE;
                            end else begin
                                lk_q[k] <= lk_q[k] - LK_W'(1);
                            end
                        end
                        default: begin
                            st_q[k]   <= S_OFF;
                            cool_q[k] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Door timers (saturating) with alarm at the limit, plus compartment power status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_COMP; k++) begin
                dc_q[k] <= '0;
            end
            alarm_q <= '0;
            cpwr_q  <= '0;
        end else begin
            cpwr_q <= powered_c;
            for (int unsigned k = 0; k < N_COMP; k++) begin
                if (powered_c[k] && bus.door[k]) begin
                    if (dc_q[k] == DC_W'(DOOR_LIMIT)) begin
                        alarm_q[k] <= 1'b1;
                    end else begin
                        dc_q[k]    <= dc_q[k] + DC_W'(1);
                        alarm_q[k] <= (dc_q[k] == DC_W'(DOOR_LIMIT - 1));
                    end
                end else begin
                    dc_q[k]    <= '0;
                    alarm_q[k] <= 1'b0;
                end
            end
        end
    end

    // Flatten per-compartment registers onto the output buses
    always_comb begin
        bus.setpt = '0;
        bus.cap   = '0;
        for (int unsigned k = 0; k < N_COMP; k++) begin
            bus.setpt[k*W +: W] = setpt_q[k];
            bus.cap[k*W +: W]   = cap_q[k];
        end
    end

    assign bus.cool_on  = cool_q;
    assign bus.comp_pwr = cpwr_q;
    assign bus.alarm    = alarm_q;
    assign bus.wr_ack   = wr_ack_q;

endmodule

// File: tb/tb_fridge_ctrl_multi.sv
// Bench for fridge_ctrl_multi: behavioural reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_fridge_ctrl_multi;

    localparam int N       = 4;
    localparam int W       = 5;
    localparam int SEL_W   = 3;
    localparam int HYST    = 2;
    localparam int MIN_OFF = 8;
    localparam int DLIM    = 16;
    localparam int DEF     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fridge_ctrl_multi_if #(.N_COMP(N), .W(W), .SEL_W(SEL_W)) bus ();

    fridge_ctrl_multi #(
        .N_COMP(N), .W(W), .SEL_W(SEL_W), .HYST(HYST),
        .MIN_OFF(MIN_OFF), .DOOR_LIMIT(DLIM), .DEF_SETPT(DEF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: plain integers describing what each compartment is doing
    int m_setpt [N];
    int m_cap   [N];
    bit m_en    [N];
    bit m_live  [N];   // has been powered for at least one edge
    bit m_cool  [N];   // compressor running
    int m_lock  [N];   // cycles of forced-off time still to serve
    int m_door  [N];   // consecutive powered door-open cycles, saturating
    bit m_cpwr  [N];
    bit m_ack;

    bit mo_acc;
    bit mo_pw;
    int mo_s;
    int mo_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on every active edge, reset asynchronously
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                m_setpt[k] = DEF;
                m_cap[k]   = 0;
                m_en[k]    = 1'b0;
                m_live[k]  = 1'b0;
                m_cool[k]  = 1'b0;
                m_lock[k]  = 0;
                m_door[k]  = 0;
                m_cpwr[k]  = 1'b0;
            end
            m_ack = 1'b0;
        end else begin
            mo_s   = int'(bus.sel);
            mo_acc = bus.wr_en && bus.pwr && (mo_s < N) && (bus.fld != 2'd3);
            for (int k = 0; k < N; k++) begin
                mo_pw = bus.pwr && m_en[k];
                mo_t  = int'(bus.temp_in[k*W +: W]);
                if (!mo_pw) begin
                    m_live[k] = 1'b0;
                    m_cool[k] = 1'b0;
                    m_lock[k] = 0;
                end else if (!m_live[k]) begin
                    m_live[k] = 1'b1;
                end else if (m_lock[k] > 0) begin
                    m_lock[k] = m_lock[k] - 1;
                end else if (m_cool[k]) begin
                    if (mo_t <= m_setpt[k]) begin
                        m_cool[k] = 1'b0;
                        m_lock[k] = MIN_OFF;
                    end
                end else if (mo_t > m_setpt[k] + HYST) begin
                    m_cool[k] = 1'b1;
                end
                if (mo_pw && bus.door[k])
                    m_door[k] = (m_door[k] < DLIM) ? m_door[k] + 1 : DLIM;
                else
                    m_door[k] = 0;
                m_cpwr[k] = mo_pw;
            end
            if (mo_acc) begin
                case (bus.fld)
                    2'd0:    m_setpt[mo_s] = int'(bus.wr_data);
                    2'd1:    m_cap[mo_s]   = int'(bus.wr_data);
                    2'd2:    m_en[mo_s]    = bus.wr_data[0];
                    default: ;
                endcase
            end
            m_ack = mo_acc;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("setpt[%0d]", k),    int'(bus.setpt[k*W +: W]), m_setpt[k]);
                chk($sformatf("cap[%0d]", k),      int'(bus.cap[k*W +: W]),   m_cap[k]);
                chk($sformatf("cool_on[%0d]", k),  int'(bus.cool_on[k]),      int'(m_cool[k]));
                chk($sformatf("comp_pwr[%0d]", k), int'(bus.comp_pwr[k]),     int'(m_cpwr[k]));
                chk($sformatf("alarm[%0d]", k),    int'(bus.alarm[k]),        int'(m_door[k] == DLIM));
            end
            chk("wr_ack", int'(bus.wr_ack), int'(m_ack));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wr(input int s, input int f, input int d);
        bus.sel     = SEL_W'(s);
        bus.fld     = 2'(f);
        bus.wr_data = W'(d);
        bus.wr_en   = 1'b1;
        cyc(1);
        bus.wr_en   = 1'b0;
    endtask

    task automatic set_temp(input int k, input int v);
        bus.temp_in[k*W +: W] = W'(v);
    endtask

    initial begin
        bus.pwr     = 1'b0;
        bus.sel     = '0;
        bus.fld     = '0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.temp_in = '0;
        bus.door    = '0;
        #1 rst_n = 1'b0;
        #22 rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_setpt", 32'(bus.setpt), 32'h21084);
        chk("rst_cool",  32'(bus.cool_on), 0);
        chk("rst_cap",   32'(bus.cap), 0);

        // Writes without power are ignored
        wr(0, 2, 1);
        chk("ack_unpowered", int'(bus.wr_ack), 0);
        bus.pwr = 1'b1;
        cyc(1);

        // Enable compartments 0..2, then a setpoint write with its ack pulse
        wr(0, 2, 1);
        chk("ack_enable", int'(bus.wr_ack), 1);
        wr(1, 2, 1);
        wr(2, 2, 1);
        cyc(1);
        chk("ack_drop", int'(bus.wr_ack), 0);
        wr(2, 0, 10);
        chk("setpt2_write", int'(bus.setpt[2*W +: W]), 10);
        chk("ack_pulse", int'(bus.wr_ack), 1);
        cyc(1);
        chk("ack_single", int'(bus.wr_ack), 0);

        // Rejected writes: selector beyond range, reserved field
        wr(5, 0, 20);
        chk("ack_sel_range", int'(bus.wr_ack), 0);
        wr(1, 3, 20);
        chk("ack_fld_rsvd", int'(bus.wr_ack), 0);
        chk("setpt1_kept", int'(bus.setpt[1*W +: W]), 4);

        // Hysteresis and lockout on compartment 0 (setpoint 4, band 2)
        set_temp(0, 6);
        cyc(3);
        chk("hys_temp6", int'(bus.cool_on[0]), 0);
        set_temp(0, 7);
        cyc(1);
        chk("hys_temp7", int'(bus.cool_on[0]), 1);
        set_temp(0, 5);
        cyc(2);
        chk("hys_temp5", int'(bus.cool_on[0]), 1);
        set_temp(0, 4);
        cyc(1);
        chk("hys_temp4", int'(bus.cool_on[0]), 0);
        set_temp(0, 20);
        for (int i = 0; i < MIN_OFF; i++) begin
            cyc(1);
            chk("lockout_hold", int'(bus.cool_on[0]), 0);
        end
        cyc(1);
        chk("lockout_resume", int'(bus.cool_on[0]), 1);

        // Threshold above the temperature range never starts cooling
        wr(2, 0, 30);
        set_temp(2, 31);
        cyc(4);
        chk("sat_no_cool", int'(bus.cool_on[2]), 0);
        chk("sat_setpt", int'(bus.setpt[2*W +: W]), 30);

        // Door alarm on compartment 1
        bus.door[1] = 1'b1;
        cyc(15);
        chk("door_15", int'(bus.alarm[1]), 0);
        cyc(1);
        chk("door_16", int'(bus.alarm[1]), 1);
        cyc(3);
        chk("door_held", int'(bus.alarm[1]), 1);
        bus.door[1] = 1'b0;
        cyc(1);
        chk("door_release", int'(bus.alarm[1]), 0);
        bus.door[1] = 1'b1;
        cyc(10);
        bus.door[1] = 1'b0;
        cyc(1);
        bus.door[1] = 1'b1;
        cyc(10);
        chk("door_interrupted", int'(bus.alarm[1]), 0);

        // Power drop while cooling with an alarm raised, then power return
        cyc(6);
        chk("pd_alarm_before", int'(bus.alarm[1]), 1);
        chk("pd_cool_before", int'(bus.cool_on[0]), 1);
        bus.pwr = 1'b0;
        cyc(1);
        chk("pd_cool", 32'(bus.cool_on), 0);
        chk("pd_alarm", 32'(bus.alarm), 0);
        chk("pd_comp_pwr", 32'(bus.comp_pwr), 0);
        chk("pd_setpt0", int'(bus.setpt[0*W +: W]), 4);
        chk("pd_setpt2", int'(bus.setpt[2*W +: W]), 30);
        cyc(2);
        bus.pwr = 1'b1;
        cyc(1);
        chk("pu_comp_pwr", 32'(bus.comp_pwr), 32'h7);
        chk("pu_idle", int'(bus.cool_on[0]), 0);
        cyc(1);
        chk("pu_cool", int'(bus.cool_on[0]), 1);

        // Asynchronous reset in mid-cycle while cooling, alarmed and acking
        cyc(15);
        chk("rs_alarm_before", int'(bus.alarm[1]), 1);
        wr(3, 1, 7);
        chk("rs_ack_before", int'(bus.wr_ack), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_setpt", 32'(bus.setpt), 32'h21084);
        chk("rs_cool", 32'(bus.cool_on), 0);
        chk("rs_alarm", 32'(bus.alarm), 0);
        chk("rs_ack", int'(bus.wr_ack), 0);
        chk("rs_cap", 32'(bus.cap), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        bus.door = '0;
        @(negedge clk);

        // Setpoint raised during cooling ends the run on the next comparison
        wr(0, 2, 1);
        cyc(2);
        chk("sw_cool", int'(bus.cool_on[0]), 1);
        wr(0, 0, 25);
        chk("sw_still_cool", int'(bus.cool_on[0]), 1);
        cyc(1);
        chk("sw_stop", int'(bus.cool_on[0]), 0);
        cyc(12);
        chk("sw_no_restart", int'(bus.cool_on[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
